// File: rtl/rtc_pkg.sv
// Shared constants for the RTC write path: sequencer state encoding,
// RTC register address table and the sequence length limit.
package rtc_pkg;

    // Sequencer states (kept as plain constants for legacy compatibility)
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_NEXT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // RTC register addresses written by one sequence, in transaction order
    localparam logic [7:0] DIR_SEG  = 8'h21;
    localparam logic [7:0] DIR_MIN  = 8'h22;
    localparam logic [7:0] DIR_HORA = 8'h23;
    localparam logic [7:0] DIR_DIA  = 8'h24;
    localparam logic [7:0] DIR_MES  = 8'h25;
    localparam logic [7:0] DIR_ANIO = 8'h26;

    // indice is 3 bits wide, so at most 8 transactions per sequence
    localparam int unsigned NUM_REGS_MAX = 8;

    // Address for transaction idx; slots beyond the six RTC registers read 0
    function automatic logic [7:0] dir_addr(input logic [2:0] idx);
        logic [7:0] a;
        case (idx)
            3'd0:    a = DIR_SEG;
            3'd1:    a = DIR_MIN;
            3'd2:    a = DIR_HORA;
            3'd3:    a = DIR_DIA;
            3'd4:    a = DIR_MES;
            3'd5:    a = DIR_ANIO;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/watchdog_escritura.sv
// Transaction watchdog for the write sequencer: counts cycles from inicio
// while the sequencer waits for end_flag and raises a sticky err on expiry.
module watchdog_escritura
    import rtc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023
)
(
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    input  logic i_end,
    output logic o_expire,
    output logic o_err
);

    // The counter is loaded with 1 on inicio so the START cycle is counted;
    // expiry fires in the WAIT cycle that would bring the count to TIMEOUT.
    localparam logic [9:0] LIMIT = 10'(TIMEOUT - 1);

    logic [9:0] r_cnt;
    logic       r_err;

    assign o_expire = i_en & ~i_end & (r_cnt == LIMIT);
    assign o_err    = r_err;

    // Cycle counter: restart on inicio, advance every WAIT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= 10'd1;
        end else if (i_en) begin
            r_cnt <= r_cnt + 10'd1;
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (o_expire) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: rtl/secuenciador_escritura.sv
// RTC write sequencer: on go, snapshots six BCD bytes and runs one write
// transaction per byte through the write FSM (inicio / end_flag handshake),
// steering the shared bus from the FSM's AD and Data strobes.
// Optional macro SEQ_TIMEOUT_EN adds a per-transaction watchdog and err port.
module secuenciador_escritura
    import rtc_pkg::*;
#(
    parameter int unsigned NUM_REGS = 6,
    parameter int unsigned TIMEOUT  = 1023
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [7:0] seg_in,
    input  logic [7:0] min_in,
    input  logic [7:0] hora_in,
    input  logic [7:0] dia_in,
    input  logic [7:0] mes_in,
    input  logic [7:0] anio_in,
    input  logic       end_flag,
    input  logic       ad_in,
    input  logic       data_in,
    output logic       inicio,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic [2:0] indice,
    output logic       busy,
    output logic       done
`ifdef SEQ_TIMEOUT_EN
    ,
    output logic       err
`endif
);

    if (NUM_REGS < 1 || NUM_REGS > NUM_REGS_MAX) begin : g_bad_num_regs
        $error("secuenciador_escritura: NUM_REGS must be 1..8");
    end
    if (TIMEOUT < 2 || TIMEOUT > 1023) begin : g_bad_timeout
        $error("secuenciador_escritura: TIMEOUT must fit the 10-bit watchdog");
    end

    localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);

    logic [2:0] r_state;
    logic [2:0] r_indice;
    logic [7:0] r_dato [NUM_REGS_MAX];
    logic       w_expire;
    logic [7:0] w_dir;
    logic [7:0] w_dato;

`ifdef SEQ_TIMEOUT_EN
    watchdog_escritura #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (reset),
        .i_clear  (inicio),
        .i_en     (r_state == ST_WAIT),
        .i_end    (end_flag),
        .o_expire (w_expire),
        .o_err    (err)
    );
`else
    assign w_expire = 1'b0;
`endif

    // Sequence control: accept go, pulse inicio, wait end_flag, step index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_indice <= '0;
            for (int unsigned i = 0; i < NUM_REGS_MAX; i++) begin
                r_dato[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (go) begin
                        r_dato[0] <= seg_in;
                        r_dato[1] <= min_in;
                        r_dato[2] <= hora_in;
                        r_dato[3] <= dia_in;
                        r_dato[4] <= mes_in;
                        r_dato[5] <= anio_in;
                        r_dato[6] <= '0;
                        r_dato[7] <= '0;
                        r_indice  <= '0;
                        r_state   <= ST_START;
                    end
                end
                ST_START: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (end_flag) begin
                        r_state <= (r_indice == LAST_IDX) ? ST_DONE : ST_NEXT;
                    end else if (w_expire) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_NEXT: begin
                    r_indice <= r_indice + 3'd1;
                    r_state  <= ST_START;
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign inicio = (r_state == ST_START);
    assign done   = (r_state == ST_DONE);
    assign busy   = (r_state != ST_IDLE);
    assign indice = r_indice;

    // Bus steering follows the write FSM strobes with no added latency.
    // bus_out is forced to 0 outside a sequence so reset leaves every output at 0.
    assign w_dir   = dir_addr(r_indice);
    assign w_dato  = r_dato[r_indice];
    assign bus_out = busy ? (ad_in ? w_dato : w_dir) : '0;
    assign bus_oe  = data_in & busy;

endmodule

// File: tb/tb_secuenciador_escritura.sv
module tb_secuenciador_escritura;

    logic       clk;
    logic       reset;
    logic       go;
    logic [7:0] seg_in, min_in, hora_in, dia_in, mes_in, anio_in;
    logic       end_flag;
    logic       ad_in;
    logic       data_in;
    logic       inicio;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [2:0] indice;
    logic       busy;
    logic       done;
`ifdef SEQ_TIMEOUT_EN
    logic       err;
`endif

    int checks   = 0;
    int failures = 0;
    int n_inicio = 0;
    int n_done   = 0;

    secuenciador_escritura #(
        .NUM_REGS (6),
        .TIMEOUT  (1023)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .seg_in   (seg_in),
        .min_in   (min_in),
        .hora_in  (hora_in),
        .dia_in   (dia_in),
        .mes_in   (mes_in),
        .anio_in  (anio_in),
        .end_flag (end_flag),
        .ad_in    (ad_in),
        .data_in  (data_in),
        .inicio   (inicio),
        .bus_out  (bus_out),
        .bus_oe   (bus_oe),
        .indice   (indice),
        .busy     (busy),
        .done     (done)
`ifdef SEQ_TIMEOUT_EN
        ,
        .err      (err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (inicio === 1'b1) n_inicio++;
        if (done === 1'b1) n_done++;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish (time=%0t, required < 2000000)", $time);
        $fatal(1, "bench time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_payload(input logic [7:0] p [6]);
        seg_in = p[0]; min_in = p[1]; hora_in = p[2];
        dia_in = p[3]; mes_in = p[4]; anio_in = p[5];
    endtask

    // Write-FSM stand-in: wait for inicio, probe bus in both phases,
    // then return end_flag lat cycles after inicio.
    task automatic do_txn(input int lat, output logic saw, output int gap,
                          output logic [2:0] idx, output logic [7:0] addr,
                          output logic [7:0] dat, output logic oe_on,
                          output logic oe_off);
        saw = 1'b0; gap = 0; idx = 'x; addr = 'x; dat = 'x; oe_on = 'x; oe_off = 'x;
        while (!saw && gap < 40) begin
            if (inicio === 1'b1) saw = 1'b1;
            else begin
                tick();
                gap++;
            end
        end
        if (saw) begin
            idx = indice;
            ad_in = 1'b0; data_in = 1'b1; #1;
            addr = bus_out; oe_on = bus_oe;
            ad_in = 1'b1; #1;
            dat = bus_out;
            data_in = 1'b0; #1;
            oe_off = bus_oe;
            ad_in = 1'b0;
            repeat (lat - 1) tick();
            end_flag = 1'b1;
            tick();
            end_flag = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [7:0] p [6];
        p = '{8'h45, 8'h30, 8'h12, 8'h31, 8'h12, 8'h99};
        set_payload(p);
        reset = 1'b1; go = 1'b1;
        repeat (3) tick();
        checks++;
        if ({inicio, busy, done, bus_oe, indice, bus_out} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs: got inicio=%b busy=%b done=%b oe=%b idx=%0d bus=%h, required all 0",
                     inicio, busy, done, bus_oe, indice, bus_out);
        end
`ifdef SEQ_TIMEOUT_EN
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err: got %b, required 0", err);
        end
`endif
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({inicio, busy} !== 2'b00) begin
            failures++;
            $display("FAIL release_before_edge: got inicio=%b busy=%b, required 0 0", inicio, busy);
        end
        tick();
        checks++;
        if (inicio !== 1'b1 || indice !== 3'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL first_accept: got inicio=%b idx=%0d busy=%b, required 1 0 1", inicio, indice, busy);
        end
        go = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_full_sequence();
        logic [7:0] p [6];
        logic [7:0] a [6];
        logic       saw, oe_on, oe_off;
        int         gap, bi, bd;
        logic [2:0] idx;
        logic [7:0] addr, dat;
        p = '{8'h45, 8'h30, 8'h12, 8'h31, 8'h12, 8'h99};
        a = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
        set_payload(p);
        bi = n_inicio; bd = n_done;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int i = 0; i < 6; i++) begin
            do_txn(352, saw, gap, idx, addr, dat, oe_on, oe_off);
            checks++;
            if (!saw || idx !== 3'(i) || addr !== a[i] || dat !== p[i]) begin
                failures++;
                $display("FAIL seq_txn%0d: got saw=%b idx=%0d addr=%h data=%h, required 1 %0d %h %h",
                         i, saw, idx, addr, dat, i, a[i], p[i]);
            end
            checks++;
            if (oe_on !== 1'b1 || oe_off !== 1'b0) begin
                failures++;
                $display("FAIL seq_oe%0d: got oe(data=1)=%b oe(data=0)=%b, required 1 0", i, oe_on, oe_off);
            end
            // NEXT then START: one edge after the end_flag edge
            if (i > 0) begin
                checks++;
                if (gap !== 1) begin
                    failures++;
                    $display("FAIL seq_gap%0d: got %0d edges, required 1", i, gap);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL done_pulse: got done=%b busy=%b, required 1 1", done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_exit: got done=%b busy=%b, required 0 0", done, busy);
        end
        repeat (3) tick();
        checks++;
        if (n_inicio - bi !== 6 || n_done - bd !== 1) begin
            failures++;
            $display("FAIL seq_counts: got inicio=%0d done=%0d, required 6 1", n_inicio - bi, n_done - bd);
        end
    endtask

    task automatic test_snapshot();
        logic [7:0] pa [6];
        logic [7:0] pb [6];
        logic       saw, oe_on, oe_off;
        int         gap, bi, bd;
        logic [2:0] idx;
        logic [7:0] addr, dat;
        pa = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        pb = '{8'h59, 8'h59, 8'h23, 8'h28, 8'h02, 8'h00};
        set_payload(pa);
        bi = n_inicio; bd = n_done;
        go = 1'b1;
        tick();
        set_payload(pb);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) go = 1'b0;
            do_txn(10, saw, gap, idx, addr, dat, oe_on, oe_off);
            checks++;
            if (!saw || dat !== pa[i]) begin
                failures++;
                $display("FAIL snap_data%0d: got saw=%b data=%h, required 1 %h", i, saw, dat, pa[i]);
            end
        end
        go = 1'b0;
        repeat (5) tick();
        checks++;
        if (n_inicio - bi !== 6 || n_done - bd !== 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL snap_counts: got inicio=%0d done=%0d busy=%b, required 6 1 0",
                     n_inicio - bi, n_done - bd, busy);
        end
        // end_flag while idle must not start anything
        end_flag = 1'b1;
        tick();
        end_flag = 1'b0;
        repeat (3) tick();
        checks++;
        if (n_inicio - bi !== 6 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_end_flag: got inicio=%0d busy=%b, required 6 0", n_inicio - bi, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic       saw, oe_on, oe_off;
        int         gap, bi;
        logic [2:0] idx;
        logic [7:0] addr, dat;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_txn(5, saw, gap, idx, addr, dat, oe_on, oe_off);
        end
        gap = 0;
        while (inicio !== 1'b1 && gap < 40) begin
            tick();
            gap++;
        end
        repeat (3) tick();
        ad_in = 1'b1; data_in = 1'b1; #1;
        checks++;
        if (indice !== 3'd3 || bus_oe !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre_reset: got idx=%0d oe=%b busy=%b, required 3 1 1", indice, bus_oe, busy);
        end
        reset = 1'b1; #1;
        checks++;
        if ({inicio, busy, done, bus_oe, indice, bus_out} !== 15'd0) begin
            failures++;
            $display("FAIL mid_async_reset: got inicio=%b busy=%b done=%b oe=%b idx=%0d bus=%h, required all 0",
                     inicio, busy, done, bus_oe, indice, bus_out);
        end
        ad_in = 1'b0; data_in = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        bi = n_inicio;
        repeat (20) tick();
        checks++;
        if (n_inicio !== bi || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_after_release: got inicio=%0d busy=%b, required 0 0", n_inicio - bi, busy);
        end
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int c, bd;
        bd = n_done;
        go = 1'b1;
        tick();
        go = 1'b0;
        checks++;
        if (inicio !== 1'b1) begin
            failures++;
            $display("FAIL to_inicio: got %b, required 1", inicio);
        end
        c = 0;
        while (err !== 1'b1 && c < 1100) begin
            tick();
            c++;
        end
        checks++;
        if (c !== 1023) begin
            failures++;
            $display("FAIL to_latency: got %0d cycles, required 1023", c);
        end
        checks++;
        if (busy !== 1'b0 || bus_oe !== 1'b0) begin
            failures++;
            $display("FAIL to_idle: got busy=%b oe=%b, required 0 0", busy, bus_oe);
        end
        repeat (10) tick();
        checks++;
        if (err !== 1'b1 || n_done !== bd) begin
            failures++;
            $display("FAIL to_sticky: got err=%b done_pulses=%0d, required 1 0", err, n_done - bd);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL to_clear: got %b, required 0", err);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; go = 1'b0; end_flag = 1'b0; ad_in = 1'b0; data_in = 1'b0;
        seg_in = '0; min_in = '0; hora_in = '0; dia_in = '0; mes_in = '0; anio_in = '0;
        test_reset();
        test_full_sequence();
        test_snapshot();
        test_reset_mid();
`ifdef SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
